// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the coin path, measures pulse width and
// classifies each coin into one accept/reject strobe, with sticky jam detection.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_W      = 8,
  parameter int JAM_W      = 1000,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_sense,
  input  logic size_sense,
  input  logic accept_en,
  input  logic jam_clr,
  output logic coin_valid,
  output logic coin_big,
  output logic reject,
  output logic jam
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, MEASURE, RESULT, GAP, JAM} state_t;
  state_t state;
  logic cs_m, cs_s, sz_m, sz_s, f, big, wide_enough;
  logic [DW-1:0] deb_cnt;
  logic [CNT_W-1:0] wcnt;
  logic [GW-1:0] gcnt;
  assign wide_enough = wcnt >= CNT_W'(MIN_W);
  always_ff @(posedge clk or posedge rst)
    if (rst) {cs_m, cs_s, sz_m, sz_s} <= '0;
    else {cs_s, cs_m, sz_s, sz_m} <= {cs_m, coin_sense, sz_m, size_sense};
  // f only follows cs_s after DEB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f <= 1'b0;
      deb_cnt <= '0;
    end else if (cs_s == f) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      f <= cs_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      gcnt <= '0;
      big <= 1'b0;
      coin_valid <= 1'b0;
      coin_big <= 1'b0;
      reject <= 1'b0;
      jam <= 1'b0;
    end else begin
      coin_valid <= 1'b0;
      coin_big <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE:
          if (f) begin
            state <= MEASURE;
            wcnt <= CNT_W'(1);
            big <= sz_s;
          end
        MEASURE:
          if (!f) begin
            state <= RESULT;
          end else begin
            wcnt <= (&wcnt) ? wcnt : wcnt + 1'b1;
            big <= big | sz_s;
            if (wcnt >= CNT_W'(JAM_W - 1)) begin
              state <= JAM;
              jam <= 1'b1;
            end
          end
        RESULT: begin
          reject <= !accept_en || !wide_enough;
          coin_valid <= accept_en && wide_enough;
          coin_big <= accept_en && wide_enough && big;
          gcnt <= '0;
          state <= GAP;
        end
        GAP:
          if (gcnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
          else gcnt <= gcnt + 1'b1;
        JAM:
          if (!f && jam_clr) begin
            state <= IDLE;
            jam <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage placed directly upstream of the vending machine FSM.
- Conditions the raw coin-path sensors: synchronises, debounces, measures the pulse width and classifies the coin size.
- Emits exactly one single-cycle strobe per accepted coin on coin_valid/coin_big, which drive the vending machine's i/j inputs.
- Flags short/disabled coins as rejects and detects a stuck coin path (jam).

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised cycles required before the filtered level changes.
- MIN_W, 8: minimum filtered-high width in cycles for a valid coin.
- JAM_W, 1000: filtered-high width at which a jam is declared.
- GAP_CYCLES, 2: idle holdoff after every outcome before a new coin is measured.
- CNT_W, 10: width counter bits; must satisfy 2^CNT_W > JAM_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_sense  in  1  raw coin-present sensor, asynchronous to clk.
- size_sense  in  1  raw large-coin sensor, asynchronous; high while a 10-unit coin passes.
- accept_en  in  1  synchronous; 0 = coins are returned (reported as reject).
- jam_clr  in  1  synchronous; clears the jam flag.
- coin_valid  out  1  one-cycle strobe for an accepted coin (to vending machine i).
- coin_big  out  1  valid only with coin_valid; 1 = 10-unit coin (to vending machine j); 0 whenever coin_valid = 0.
- reject  out  1  one-cycle strobe when a coin is returned.
- jam  out  1  sticky jam level.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On rst, all of the following clear immediately, independent of clk: synchroniser flops, debounce counter, filtered level f, width counter, big latch, FSM to IDLE, and outputs coin_valid, coin_big, reject, jam = 0.
- Reset mid-measurement discards the coin; no strobe is issued after release.
- Synchronisers: two flops each on coin_sense and size_sense, giving cs_s and sz_s.
- Debounce on coin_sense only:
  - deb_cnt clears whenever cs_s == f; otherwise it increments.
  - When deb_cnt reaches DEB_CYCLES-1 with cs_s != f, f <= cs_s and deb_cnt clears.
  - Glitches shorter than DEB_CYCLES are never seen downstream.
  - Fixed latency from a raw edge to f = 2 + DEB_CYCLES cycles.
- FSM states IDLE, MEASURE, RESULT, GAP, JAM (registered outputs):
  - IDLE: f = 1 -> MEASURE; set wcnt = 1 and big = sz_s.
  - MEASURE, f = 1: wcnt++ (saturating) and big |= sz_s. When wcnt reaches JAM_W -> JAM.
  - MEASURE, f = 0 -> RESULT.
  - RESULT (one cycle), evaluated in this priority order:
    - accept_en = 0 -> reject = 1 for the next cycle.
    - else wcnt < MIN_W -> reject = 1.
    - else coin_valid = 1 and coin_big = big.
    - Then -> GAP.
  - GAP: stays GAP_CYCLES cycles with all strobes 0, then -> IDLE. A coin already high at IDLE entry is measured from that cycle; its width is short by the elapsed gap.
  - JAM: jam = 1 while in JAM, and no strobes. Exits to IDLE only in a cycle where f = 0 and jam_clr = 1, after which jam = 0.
  - jam_clr with f still high, or jam_clr outside JAM, has no effect.
- Strobe rules:
  - coin_valid and reject are mutually exclusive and never asserted on consecutive cycles.
  - Each strobe is exactly one clk wide, since the downstream FSM counts every high cycle of i.
  - Strobes appear one cycle after RESULT; the strobe cycle coincides with the first GAP cycle.
- accept_en is sampled only in RESULT. Toggling it during MEASURE does not affect the outcome.
- size_sense asserting alone, with coin_sense low, produces nothing.
- wcnt saturates and never wraps.

Test Plan:
- Reset behaviour: assert rst asynchronously mid-MEASURE with coin_sense held high for 20 cycles -> all outputs 0 immediately. After release, no strobe until a new f rise.
- Small coin: defaults; coin_sense high 20 cycles, size_sense low, accept_en = 1 -> exactly one coin_valid = 1 with coin_big = 0. Strobe occurs 2 + 4 + 2 cycles after the raw fall; reject and jam stay 0.
- Large coin, back-to-back: coin_sense high 20 cycles with size_sense high for cycles 5-12, then a second coin 10 cycles later -> two separate coin_valid strobes, each with coin_big = 1, never adjacent.
- Glitch and short coin: a 3-cycle coin_sense pulse -> no output. A 6-cycle pulse -> reject = 1 for one cycle, coin_valid stays 0.
- Disabled path: accept_en = 0 at the fall of a valid 20-cycle coin -> reject pulse only.
- Jam: coin_sense held high 1100 cycles -> jam = 1 once width reaches 1000.
  - jam_clr while coin_sense is still high -> jam stays 1.
  - Drop coin_sense, wait for f = 0, then pulse jam_clr -> jam = 0.
  - A subsequent 20-cycle coin is accepted normally.
